mem_access_unit: RTL

Load/store front end for the MIPS data-memory stage. Accepts one load or store per request from the MEM pipeline stage, checks alignment, and drives the word-addressed data RAM directly upstream of it. Sub-word stores (SB/SH) run as read-modify-write; sub-word loads (LB/LBU/LH/LHU) are extracted and sign- or zero-extended. Byte order is big-endian: byte offset 0 is bits [31:24].

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/load_store_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and lane helpers for the data-memory access unit
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam int BYTE_BITS = 8;
    localparam int HALF_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Big-endian: byte offset 0 sits in the top byte, so its LSB is bit 24.
    function automatic logic [4:0] byte_lane_lsb(input logic [1:0] off);
        return 5'(BYTE_BITS * (3 - int'(off)));
    endfunction

    // Half offset 0 is [31:16], half offset 2 is [15:0].
    function automatic logic [4:0] half_lane_lsb(input logic [1:0] off);
        return off[1] ? 5'd0 : 5'(HALF_BITS);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - lane extraction/extension for loads and lane merge for sub-word stores
module load_store_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_lane;

    // Select the lane position and width addressed by offset/size.
    always_comb begin
        w_shift = 5'd0;
        w_mask  = 32'hFFFF_FFFF;
        case (i_size)
            SIZE_BYTE: begin
                w_shift = byte_lane_lsb(i_offset);
                w_mask  = 32'h0000_00FF;
            end
            SIZE_HALF: begin
                w_shift = half_lane_lsb(i_offset);
                w_mask  = 32'h0000_FFFF;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign w_lane = (i_word >> w_shift) & w_mask;

    // Sign- or zero-extend the extracted lane; full words pass through.
    always_comb begin
        o_load_data = w_lane;
        if (!i_unsigned) begin
            case (i_size)
                SIZE_BYTE: o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
                SIZE_HALF: o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
                default:   o_load_data = w_lane;
            endcase
        end
    end

    assign o_merged_word = (i_word & ~(w_mask << w_shift)) | ((i_store_data & w_mask) << w_shift);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store front end driving the word-addressed data RAM
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_load,
    input  logic                  i_req_store,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    output logic                  o_ram_write_en,
    output logic                  o_ram_read_en,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_load;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_merge;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    assign w_accept     = i_req_valid && (r_state == ST_IDLE);
    assign w_illegal    = (i_req_size == SIZE_ILLEGAL) || (i_req_load == i_req_store);
    assign w_misaligned = ((i_req_size == SIZE_HALF) && i_req_addr[0]) ||
                          ((i_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00));
    assign w_err        = w_illegal || w_misaligned;
    assign w_word_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    load_store_align u_align (
        .i_word        (i_ram_rdata),
        .i_offset      (r_addr[1:0]),
        .i_size        (r_size),
        .i_unsigned    (r_unsigned),
        .i_store_data  (r_wdata),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode: errors skip the RAM, SW skips the read.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)                                       w_next_state = ST_RESP;
                    else if (i_req_store && (i_req_size == SIZE_WORD)) w_next_state = ST_WRITE;
                    else                                             w_next_state = ST_READ;
                end
            end
            ST_READ:  w_next_state = r_load ? ST_RESP : ST_WRITE;
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from state and latched request only; write strobe is masked by reset.
    always_comb begin
        o_req_ready    = 1'b0;
        o_resp_valid   = 1'b0;
        o_ram_read_en  = 1'b0;
        o_ram_write_en = 1'b0;
        o_ram_addr     = '0;
        o_ram_wdata    = '0;
        case (r_state)
            ST_IDLE: o_req_ready = 1'b1;
            ST_READ: begin
                o_ram_read_en = 1'b1;
                o_ram_addr    = w_word_addr;
            end
            ST_WRITE: begin
                o_ram_write_en = !reset;
                o_ram_addr     = w_word_addr;
                o_ram_wdata    = (r_size == SIZE_WORD) ? r_wdata : r_merge;
            end
            ST_RESP: o_resp_valid = 1'b1;
            default: o_req_ready = 1'b0;
        endcase
    end

    // Request latch, load result and sub-word merge registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load     <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_merge    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_load     <= i_req_load;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_rdata    <= '0;
            r_err      <= w_err;
        end else if (r_state == ST_READ) begin
            if (r_load) r_rdata <= w_load_data;
            else        r_merge <= w_merged;
        end
    end

    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

endmodule
